mhp_tx: RTL

MHP_TX -- requirements
Module: mhp_tx

---
 rtl/mhp_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mhp_tx.sv
// MHP frame transmitter: serialises a 7-byte header and the payload onto a one-byte output register.
// Optional trailing checksum (SCS) is enabled by defining MHP_TX_CHKSUM_EN.
module mhp_tx #(
    parameter logic [15:0] CHK_INIT = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_src,
    input  logic [15:0] i_size,
    input  logic [7:0]  i_dtype,
    input  logic [7:0]  i_pdata,
    input  logic        i_pvalid,
    output logic        o_pready,
    output logic [7:0]  o_wdata,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DST     = 3'd1;
    localparam logic [2:0] SRC     = 3'd2;
    localparam logic [2:0] SIZE    = 3'd3;
    localparam logic [2:0] DTYPE   = 3'd4;
    localparam logic [2:0] PAYLOAD = 3'd5;
`ifdef MHP_TX_CHKSUM_EN
    localparam logic [2:0] SCS     = 3'd6;
`endif

    logic [2:0]  state;
    logic        sel;
    logic        tail;
    logic [15:0] cnt;
    logic [7:0]  dst_lo;
    logic [15:0] src_q;
    logic [7:0]  dtype_q;
`ifdef MHP_TX_CHKSUM_EN
    logic [15:0] chk;
    logic        par;
`endif

    logic       ld_ok;
    logic       nb_ld;
    logic [7:0] nb;

    assign ld_ok    = !o_wvalid || i_wready;
    assign o_pready = (state == PAYLOAD) && !tail && ld_ok;

    // cnt doubles as the latched size until PAYLOAD starts counting it down
    always_comb begin
        nb = '0;
        case (state)
            DST:     nb = dst_lo;
            SRC:     nb = sel ? src_q[7:0] : src_q[15:8];
            SIZE:    nb = sel ? cnt[7:0] : cnt[15:8];
            DTYPE:   nb = dtype_q;
            PAYLOAD: nb = i_pdata;
`ifdef MHP_TX_CHKSUM_EN
            SCS:     nb = sel ? chk[7:0] : chk[15:8];
`endif
            default: nb = '0;
        endcase
        nb_ld = ld_ok && !tail && (state != IDLE) && ((state != PAYLOAD) || i_pvalid);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            tail     <= 1'b0;
            cnt      <= '0;
            dst_lo   <= '0;
            src_q    <= '0;
            dtype_q  <= '0;
            o_wdata  <= '0;
            o_wvalid <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
`ifdef MHP_TX_CHKSUM_EN
            chk      <= CHK_INIT;
            par      <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                if (i_start) begin
                    dst_lo   <= i_dst[7:0];
                    src_q    <= i_src;
                    dtype_q  <= i_dtype;
                    cnt      <= i_size;
                    o_wdata  <= i_dst[15:8];
                    o_wvalid <= 1'b1;
                    o_busy   <= 1'b1;
                    state    <= DST;
                    sel      <= 1'b1;
                    tail     <= 1'b0;
`ifdef MHP_TX_CHKSUM_EN
                    chk      <= {CHK_INIT[15:8] ^ i_dst[15:8], CHK_INIT[7:0]};
                    par      <= 1'b1;
`endif
                end
            end else if (tail) begin
                // last byte is parked in the output register; finish once it leaves
                if (i_wready) begin
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                    o_wvalid <= 1'b0;
                    tail     <= 1'b0;
                    sel      <= 1'b0;
                    state    <= IDLE;
                end
            end else if (ld_ok) begin
                o_wvalid <= nb_ld;
                if (nb_ld) begin
                    o_wdata <= nb;
`ifdef MHP_TX_CHKSUM_EN
                    if (state != SCS) begin
                        if (par) chk[7:0]  <= chk[7:0] ^ nb;
                        else     chk[15:8] <= chk[15:8] ^ nb;
                        par <= ~par;
                    end
`endif
                    case (state)
                        DST: begin
                            state <= SRC;
                            sel   <= 1'b0;
                        end
                        SRC: begin
                            sel <= ~sel;
                            if (sel) state <= SIZE;
                        end
                        SIZE: begin
                            sel <= ~sel;
                            if (sel) state <= DTYPE;
                        end
                        DTYPE: begin
                            if (cnt != 16'd0) begin
                                state <= PAYLOAD;
                            end else begin
`ifdef MHP_TX_CHKSUM_EN
                                state <= SCS;
                                sel   <= 1'b0;
`else
                                tail  <= 1'b1;
`endif
                            end
                        end
                        PAYLOAD: begin
                            cnt <= cnt - 16'd1;
                            if (cnt == 16'd1) begin
`ifdef MHP_TX_CHKSUM_EN
                                state <= SCS;
                                sel   <= 1'b0;
`else
                                tail  <= 1'b1;
`endif
                            end
                        end
`ifdef MHP_TX_CHKSUM_EN
                        SCS: begin
                            sel <= ~sel;
                            if (sel) tail <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
